// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Keeps the fetch PC, issues in-order requests to instruction memory, and
// buffers returned {pc, instr} pairs in a 2-entry prefetch queue feeding decode.
// Responses belonging to a path abandoned by a flush are counted and discarded.
// Optional feature: define FETCH_BUBBLE_COUNT_EN to add the bubble_count port,
// a saturating count of cycles in which decode was starved.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic [31:0] branch_target,
    input  logic        stall_D,
    output logic        valid_D,
    output logic [31:0] PC_D,
    output logic [31:0] Instr_D
`ifdef FETCH_BUBBLE_COUNT_EN
    ,
    output logic [31:0] bubble_count
`endif
);

    logic [31:0] fetch_pc;

    // Prefetch queue; entry 0 is always the head shown to decode.
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic [1:0]  count;

    // PCs of requests still waiting for their response, oldest in entry 0.
    logic [31:0] pend_pc [2];
    logic [1:0]  outstanding;
    logic [1:0]  drop;

    logic        pop;
    logic        resp;
    logic        resp_keep;
    logic [2:0]  used;

    // Handshake decode: pop, accepted response, and credit usage.
    always_comb begin
        pop       = valid_D && !stall_D && !flush;
        resp      = imem_valid && (outstanding != 2'd0);
        resp_keep = resp && (drop == 2'd0) && !flush;
        // A slot freed by this cycle's pop is reusable by this cycle's
        // request, which keeps 1-cycle memory at one instruction per cycle.
        used      = 3'(count) + 3'(outstanding) - 3'(pop);
        imem_req  = !reset && !flush && (used < 3'd2);
        imem_addr = fetch_pc;
        valid_D   = (count != 2'd0);
        PC_D      = q_pc[0];
        Instr_D   = q_instr[0];
    end

    // Fetch PC: reset vector, redirect target, or advance on each issue.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset)
            fetch_pc <= RESET_PC;
        else if (flush)
            fetch_pc <= branch_target;
        else if (imem_req)
            fetch_pc <= fetch_pc + PC_STEP;
    end

    // Outstanding-request tracking: PC queue, in-flight count, drop count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_pc[0]  <= '0;
            pend_pc[1]  <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            case ({imem_req, resp})
                2'b10: begin
                    pend_pc[outstanding[0]] <= fetch_pc;
                    outstanding             <= outstanding + 2'd1;
                end
                2'b01: begin
                    pend_pc[0]  <= pend_pc[1];
                    outstanding <= outstanding - 2'd1;
                end
                2'b11: begin
                    if (outstanding == 2'd1) begin
                        pend_pc[0] <= fetch_pc;
                    end else begin
                        pend_pc[0] <= pend_pc[1];
                        pend_pc[1] <= fetch_pc;
                    end
                end
                default: ;
            endcase
            // Everything still in flight after a flush belongs to the old path.
            if (flush)
                drop <= outstanding - 2'(resp);
            else if (resp && (drop != 2'd0))
                drop <= drop - 2'd1;
        end
    end

    // Prefetch queue: push kept responses, pop on decode accept, clear on flush.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the queue storage is reset (not just count) because PC_D and
        // Instr_D come straight from the head entry and must read 0 in reset.
        if (reset) begin
            q_pc[0]    <= '0;
            q_pc[1]    <= '0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
            count      <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({pop, resp_keep})
                2'b10: begin
                    q_pc[0]    <= q_pc[1];
                    q_instr[0] <= q_instr[1];
                    count      <= count - 2'd1;
                end
                2'b01: begin
                    q_pc[count[0]]    <= pend_pc[0];
                    q_instr[count[0]] <= imem_rdata;
                    count             <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q_pc[0]    <= pend_pc[0];
                        q_instr[0] <= imem_rdata;
                    end else begin
                        q_pc[0]    <= q_pc[1];
                        q_instr[0] <= q_instr[1];
                        q_pc[1]    <= pend_pc[0];
                        q_instr[1] <= imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_BUBBLE_COUNT_EN
    // Starvation counter: saturating count of cycles decode had nothing to take.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_count <= '0;
        else if (!valid_D && !stall_D && (bubble_count != 32'hFFFF_FFFF))
            bubble_count <= bubble_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: in-order memory model with configurable latency,
// directed scenarios, then randomized stall/flush traffic checked against a
// PC-stream reference model. Build with FETCH_BUBBLE_COUNT_EN to cover the counter.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic        stall_D = 1'b0;
    logic        valid_D;
    logic [31:0] PC_D;
    logic [31:0] Instr_D;
`ifdef FETCH_BUBBLE_COUNT_EN
    logic [31:0] bubble_count;
`endif

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd2)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .flush         (flush),
        .branch_target (branch_target),
        .stall_D       (stall_D),
        .valid_D       (valid_D),
        .PC_D          (PC_D),
        .Instr_D       (Instr_D)
`ifdef FETCH_BUBBLE_COUNT_EN
        ,
        .bubble_count  (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    int          last_due;
    int          cyc;
    int          lat_fix;       // 0 selects a random latency of 1..3 per request
    int          n_checks = 0;
    int          n_pass = 0;

    // Reference model state: next address to be fetched, next PC decode must see.
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc_D;
    logic        after_flush;
    int          bub_model;

    // Samples taken at the falling edge of the last stepped cycle.
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        flush      = 1'b0;
        stall_D    = 1'b0;
        imem_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 32'(valid_D), 32'd0);
        check("rst_pc", PC_D, 32'd0);
        check("rst_instr", Instr_D, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
`ifdef FETCH_BUBBLE_COUNT_EN
        check("rst_bubble", bubble_count, 32'd0);
`endif
        mq.delete();
        last_due    = 0;
        exp_fetch   = 32'h0;
        exp_pc_D    = 32'h0;
        after_flush = 1'b0;
        bub_model   = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
    endtask

    // One clock cycle: drive inputs, sample and check at the falling edge,
    // then advance to just after the next rising edge.
    task automatic step(input logic f, input logic [31:0] tgt, input logic st);
        int lat;
        flush         = f;
        branch_target = tgt;
        stall_D       = st;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_valid = 1'b1;
            imem_rdata = word_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
        end
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = valid_D;
        s_pc    = PC_D;
`ifdef FETCH_BUBBLE_COUNT_EN
        check("bubble", bubble_count, 32'(bub_model));
        if (!valid_D && !stall_D) bub_model++;
`endif
        if (after_flush) check("post_flush_valid", 32'(valid_D), 32'd0);
        if (valid_D) begin
            check("pc_D", PC_D, exp_pc_D);
            check("instr_D", Instr_D, word_of(exp_pc_D));
        end
        if (imem_req) begin
            lat = (lat_fix == 0) ? int'($urandom_range(1, 3)) : lat_fix;
            last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            mq.push_back('{addr: imem_addr, due: last_due});
        end
        if (f) begin
            check("flush_req", 32'(imem_req), 32'd0);
            exp_fetch   = tgt;
            exp_pc_D    = tgt;
            after_flush = 1'b1;
        end else begin
            after_flush = 1'b0;
            if (imem_req) begin
                check("imem_addr", imem_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd2;
            end
            if (valid_D && !st) exp_pc_D = exp_pc_D + 32'd2;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] held;
        logic        seen;

        // Reset release with 1-cycle memory: addresses 0,2,4,6 and decode from cycle 2.
        lat_fix = 1;
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (i < 4) begin
                check("t1_req", 32'(s_req), 32'd1);
                check("t1_addr", s_addr, 32'(2 * i));
            end
            check("t1_valid", 32'(s_valid), 32'(i >= 2));
            if (i >= 2) check("t1_pc", s_pc, 32'(2 * (i - 2)));
        end

        // Stall for 5 cycles: queue fills, requests stop, head holds.
        held = s_pc + 32'd2;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check("t2_req", 32'(s_req), 32'd0);
            check("t2_valid", 32'(s_valid), 32'd1);
            check("t2_hold", s_pc, held);
        end
        step(1'b0, 32'h0, 1'b0);
        check("t2_resume0", s_pc, held);
        step(1'b0, 32'h0, 1'b0);
        check("t2_resume1", s_pc, held + 32'd2);
        repeat (3) step(1'b0, 32'h0, 1'b0);

        // Flush coinciding with a response and a stall: queue empty next cycle.
        step(1'b1, 32'h0000_0040, 1'b1);
        step(1'b0, 32'h0, 1'b0);
        check("t4_empty", 32'(s_valid), 32'd0);
        check("t4_addr", s_addr, 32'h0000_0040);
        repeat (4) step(1'b0, 32'h0, 1'b0);

        // Redirect near the top of the address space: fetch wraps to 0.
        step(1'b1, 32'hFFFF_FFFE, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        check("t5_req0", 32'(s_req), 32'd1);
        check("t5_addr0", s_addr, 32'hFFFF_FFFE);
        step(1'b0, 32'h0, 1'b0);
        check("t5_req1", 32'(s_req), 32'd1);
        check("t5_addr1", s_addr, 32'h0000_0000);
        repeat (4) step(1'b0, 32'h0, 1'b0);

        // Flush with two requests in flight on 3-cycle memory.
        lat_fix = 3;
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_0100, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        check("t3_addr", s_addr, 32'h0000_0100);
        seen = 1'b0;
        for (int i = 0; i < 15 && !seen; i++) begin
            step(1'b0, 32'h0, 1'b0);
            if (s_valid) begin
                seen = 1'b1;
                check("t3_first_pc", s_pc, 32'h0000_0100);
            end
        end
        if (!seen) check("t3_valid_timeout", 32'(s_valid), 32'd1);

        // Starvation counter over 10 cycles of 3-cycle memory, then mid-run reset.
        do_reset();
        repeat (10) step(1'b0, 32'h0, 1'b0);
`ifdef FETCH_BUBBLE_COUNT_EN
        check("t6_bubble", bubble_count, 32'(bub_model));
`endif
        repeat (3) step(1'b0, 32'h0, 1'b0);
        do_reset();

        // Randomized traffic: random latency, stalls and redirects.
        lat_fix = 0;
        for (int i = 0; i < 800; i++) begin
            logic        f;
            logic [31:0] tgt;
            f   = ($urandom_range(0, 99) < 5);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFE);
            step(f, tgt, ($urandom_range(0, 99) < 30));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
